// File: rtl/rv_pkg.sv
// rv_pkg: register-file geometry and write-back request types shared across the core
package rv_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t       addr;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant with a last-grant pointer that moves only when a grant is consumed
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   ptr
);

    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] win;

    // search from ptr+1 onward; walking backwards lets the nearest valid requester overwrite farther ones
    always_comb begin
        grant = '0;
        win   = ptr;
        idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                win        = idx;
            end
        end
    end

    // pointer starts at the last requester so requester 0 leads after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= PTR_W'(NUM_REQ - 1);
        else if (advance)
            ptr <= win;
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the register-file write port between requesters and tracks pending writes per register
module wb_arbiter
    import rv_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = XLEN,
    parameter int ADDR_W  = REG_ADDR_W,
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           reserve_en,
    input  logic [ADDR_W-1:0]              reserve_addr,
    output logic [REG_COUNT-1:0]           busy_vec,
    output logic                           rf_write_enable,
    output logic [ADDR_W-1:0]              rf_addr,
    output logic [DATA_W-1:0]              rf_write_data
);

    logic [NUM_REQ-1:0]   grant;
    logic [PTR_W-1:0]     last_grant;
    logic                 transfer;
    logic [ADDR_W-1:0]    win_addr;
    logic [DATA_W-1:0]    win_data;
    logic [REG_COUNT-1:0] busy_next;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (transfer),
        .grant   (grant),
        .ptr     (last_grant)
    );

    // no grant escapes while reset is held, so requesters keep their writes for after release
    always_comb begin
        req_ready = grant & {NUM_REQ{rst_n}};
        transfer  = |req_ready;
        win_addr  = '0;
        win_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                win_addr = req_addr[i];
                win_data = req_data[i];
            end
        end
    end

    // one-cycle output stage; x0 writes are accepted but never enable the register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_write_enable <= 1'b0;
            rf_addr         <= '0;
            rf_write_data   <= '0;
        end else if (transfer) begin
            rf_write_enable <= win_addr != '0;
            rf_addr         <= win_addr;
            rf_write_data   <= win_data;
        end else begin
            rf_write_enable <= 1'b0;
        end
    end

    // clear on commit, then set on reserve so a fresh reservation of the same register survives
    always_comb begin
        busy_next = busy_vec;
        if (rf_write_enable)
            busy_next[rf_addr] = 1'b0;
        if (reserve_en && reserve_addr != '0)
            busy_next[reserve_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy_vec <= '0;
        else
            busy_vec <= busy_next;
    end

    a_reserve_free: assert property (@(posedge clk) disable iff (!rst_n)
        !(reserve_en && reserve_addr != '0 && busy_vec[reserve_addr]
          && !(rf_write_enable && rf_addr == reserve_addr)));

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready) && int'(last_grant) < NUM_REQ);

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter and pending-write scoreboard for the 32 x 32-bit register file. Shares the register file's single write port between NUM_REQ write-back requesters (ALU, load unit, ...) with round-robin priority. Registers the winning write for one cycle before it reaches the register file. Tracks which architectural registers have an outstanding write so decode can stall on RAW hazards.

## Interface
Parameters:
- NUM_REQ, 2, number of write-back requesters (2..4)
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (32 registers)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  requester i has a write pending
- req_addr  in  NUM_REQ x ADDR_W  destination register per requester
- req_data  in  NUM_REQ x DATA_W  write data per requester
- req_ready  out  NUM_REQ  one-hot grant; transfer when valid and ready are both high
- reserve_en  in  1  decode issues an instruction with a destination register
- reserve_addr  in  ADDR_W  destination being reserved
- busy_vec  out  32  bit r set means register r has an outstanding write
- rf_write_enable  out  1  to the register file's write enable
- rf_addr  out  ADDR_W  to the register file's write address
- rf_write_data  out  DATA_W  to the register file's write data

## Operation
- Requesters hold valid, addr and data stable until ready is seen; valid never drops without a transfer.
- Arbitration is round-robin. The search starts at (last_grant + 1) mod NUM_REQ, and the first valid requester wins. At most one req_ready bit is high per cycle.
- req_ready is combinational from req_valid and the pointer. The output stage never stalls, so a sole valid requester is granted the same cycle.
- last_grant updates only on a cycle with a transfer.
- Output stage: on a transfer, rf_addr/rf_write_data load the winner's addr/data. rf_write_enable loads 1 if addr != 0, otherwise 0. With no transfer, rf_write_enable loads 0 and addr/data hold.
- x0 handling: a write to x0 is accepted (ready asserted) but never enables the register file. A reserve of x0 is ignored. busy_vec[0] is constant 0.
- Scoreboard behaviour at each rising edge:
  - Clear: if rf_write_enable is 1, clear busy_vec[rf_addr]. This is the same edge at which the register file commits the write.
  - Set: if reserve_en is 1 and reserve_addr != 0, set busy_vec[reserve_addr].
  - Same address set and cleared on one edge: set wins, because the new instruction's write is still outstanding.
- Decode must not reserve a register that is already busy. The block leaves the bit set and fires a simulation assertion.
- A transfer with no matching busy bit is legal, e.g. after a reset. It writes normally.

## Timing
- Reset (async assert, sync release) sets:
  - rf_write_enable = 0, rf_addr = 0, rf_write_data = 0
  - busy_vec = 0
  - last_grant = NUM_REQ-1, so requester 0 has first priority after reset
  - req_ready = 0 while rst_n is low
- Latency, with the transfer at edge N:
  - rf_* outputs are valid after edge N.
  - The register file is written at edge N+1, and the busy bit clears at edge N+1.
  - Readers see the new value, and busy low, from the cycle after N+1.
- Throughput: one write per cycle sustained. With all requesters valid, each is served once every NUM_REQ cycles.
- Reset mid-operation: an in-flight output-stage write is discarded, and all busy bits drop. Requesters re-present after reset, because valid was not consumed.

## Structure
- Shared package rv_pkg holds:
  - REG_COUNT = 32, REG_ADDR_W = 5, XLEN = 32
  - typedef reg_addr_t
  - typedef wb_req_t {addr, data}
- One sub-module, rr_arbiter: parameterised NUM_REQ, with inputs req and advance and outputs one-hot grant and the pointer register.
- The scoreboard and output stage stay in wb_arbiter.

## Test plan
- Reset with all requests valid → req_ready = 0 and busy_vec = 0. After release, requester 0 is granted first.
- Req0 and req1 both continuously valid (addr 3 and 4) → grants alternate 0,1,0,1. Register file writes x3, x4, ... one per cycle, each one edge after its grant.
- Reserve x5, then req1 writes x5 = 32'hDEAD_BEEF → busy_vec[5] is high until the edge that writes x5 and low the cycle after. Reading x5 then returns DEADBEEF.
- Req0 writes x0 = 32'h1234 and reserve of x0 → req_ready[0] = 1, rf_write_enable stays 0, busy_vec[0] stays 0.
- Same edge: rf write x7 commits and reserve x7 → busy_vec[7] remains 1.
- Assert rst_n low while rf_write_enable = 1 for x9 → x9 is not written, busy_vec clears immediately, and outputs return to reset values without waiting for a clock edge.
